// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, line levels and the TX state encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DIV_WIDTH  = 16;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Read handshake between the UART TX FIFO (slave) and the serializer (master).
interface uart_tx_serializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  fifo_read_enable;
   logic                  fifo_read_ack;
   logic [DATA_WIDTH-1:0] fifo_data;

   modport master (
      output fifo_read_enable,
      input  fifo_empty,
      input  fifo_read_ack,
      input  fifo_data
   );

   modport slave (
      input  fifo_read_enable,
      output fifo_empty,
      output fifo_read_ack,
      output fifo_data
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Loadable baud down-counter: bit_end pulses every div+1 enabled cycles.
// The divisor is captured on load so later changes wait for the next load.
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 load,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_end
);

   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   assign bit_end = en & (cnt_q == '0);

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load) begin
         div_d = div;
         cnt_d = div;
      end else if (bit_end) begin
         cnt_d = div_q;
      end else if (en) begin
         cnt_d = cnt_q - DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: fetches one FIFO word per frame and shifts it out LSB-first.
// Define UART_TX_PARITY_EN to add the parity_en/parity_odd inputs and the parity bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tx_enable,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 stop_bits2,
`ifdef UART_TX_PARITY_EN
   input  logic                 parity_en,
   input  logic                 parity_odd,
`endif
   uart_tx_serializer_if.master fifo_if,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   // state  | meaning
   // IDLE   | line high, waiting for tx_enable and a non-empty FIFO
   // FETCH  | read issued; lets the request cycle pass, then expects the ack
   // START  | start bit
   // DATA   | data bits, LSB first
   // PARITY | parity bit (parity build only)
   // STOP   | one or two stop bits, then chain to the next word or go idle

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rd_en_q, rd_en_d;
`ifdef UART_TX_PARITY_EN
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
`endif

   logic start_ok;
   logic fetch_hit;
   logic tick_en;
   logic bit_end;

   assign start_ok  = tx_enable & ~fifo_if.fifo_empty;
   assign fetch_hit = (state_q == ST_FETCH) & ~rd_en_q & fifo_if.fifo_read_ack;
   assign tick_en   = (state_q != ST_IDLE) & (state_q != ST_FETCH);

   uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk     (clk),
      .resetn  (resetn),
      .load    (fetch_hit),
      .en      (tick_en),
      .div     (baud_div),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      stop2_d   = stop2_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d = IDLE_LEVEL;
            if (start_ok) begin
               rd_en_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // the ack is due one cycle after the request, never during it
            if (!rd_en_q) begin
               if (fifo_if.fifo_read_ack) begin
                  shift_d   = fifo_if.fifo_data;
                  stop2_d   = stop_bits2;
                  bit_idx_d = '0;
                  tx_d      = START_LEVEL;
                  state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
                  par_en_d  = parity_en;
                  par_bit_d = (^fifo_if.fifo_data) ^ parity_odd;
`endif
               end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_IDX) begin
                  bit_idx_d = '0;
                  tx_d      = IDLE_LEVEL;
                  state_d   = ST_STOP;
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = ST_PARITY;
                  end
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  tx_d      = shift_d[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = IDLE_LEVEL;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (stop2_q && (bit_idx_q == '0)) begin
                  bit_idx_d = IDX_W'(1);
               end else begin
                  bit_idx_d = '0;
                  done_d    = 1'b1;
                  // chaining straight into FETCH gives the 2-cycle inter-frame gap
                  if (start_ok) begin
                     rd_en_d = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         stop2_q   <= 1'b0;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   assign tx                       = tx_q;
   assign busy                     = busy_q;
   assign tx_done                  = done_q;
   assign fifo_if.fifo_read_enable = rd_en_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: registered FIFO model, line monitor checking each
// frame against a scoreboard of pushed words, and directed timing/boundary steps.
module tb_uart_tx_serializer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        tx_enable;
   logic [15:0] baud_div;
   logic        stop_bits2;
`ifdef UART_TX_PARITY_EN
   logic        parity_en;
   logic        parity_odd;
`endif
   logic        tx;
   logic        busy;
   logic        tx_done;

   uart_tx_serializer_if #(.DATA_WIDTH(8)) ifc ();

   uart_tx_serializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tx_enable  (tx_enable),
      .baud_div   (baud_div),
      .stop_bits2 (stop_bits2),
`ifdef UART_TX_PARITY_EN
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
`endif
      .fifo_if    (ifc),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // FIFO model: registered read, ack one cycle after the request
   logic [7:0] push_q[$];
   logic [7:0] fifo_q[$];
   bit         flush_req;

   always @(posedge clk) begin
      ifc.fifo_read_ack <= 1'b0;
      if (ifc.fifo_read_enable === 1'b1) begin
         if (flush_req) begin
            fifo_q.delete();
         end else if (fifo_q.size() != 0) begin
            ifc.fifo_data     <= fifo_q.pop_front();
            ifc.fifo_read_ack <= 1'b1;
         end
      end
      while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
      ifc.fifo_empty <= (fifo_q.size() == 0);
   end

   // Line monitor and scoreboard
   logic [7:0]  sb[$];
   int          gaps[$];
   bit          mon_on;
   bit          in_frame = 1'b0;
   int          cyc, total, bitc, nb_m;
   int          gap_cnt = 0;
   int          frames_done = 0;
   int          re_cnt = 0;
   int          done_cnt = 0;
   logic [15:0] exp_bits;
   logic [7:0]  w_m;
   int          cfg_div;
   bit          cfg_stop2;
   bit          cfg_par_en = 1'b0;
   bit          cfg_par_odd = 1'b0;

   always @(negedge clk) begin
      if (ifc.fifo_read_enable === 1'b1) begin
         re_cnt++;
         check("re_while_empty", ifc.fifo_empty, 1'b0);
      end
      if (tx_done === 1'b1) done_cnt++;
      if (!mon_on) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (tx === 1'b0) begin
            gaps.push_back(gap_cnt);
            check("frame_expected", sb.size() != 0, 1'b1);
            w_m = 8'h00;
            if (sb.size() != 0) w_m = sb.pop_front();
            exp_bits      = '1;
            exp_bits[0]   = 1'b0;
            exp_bits[8:1] = w_m;
            nb_m          = 9;
            if (cfg_par_en) begin
               exp_bits[9] = (^w_m) ^ cfg_par_odd;
               nb_m        = 10;
            end
            nb_m     = nb_m + (cfg_stop2 ? 2 : 1);
            bitc     = cfg_div + 1;
            total    = nb_m * bitc;
            cyc      = 0;
            in_frame = 1'b1;
         end else if (tx === 1'b1) begin
            gap_cnt++;
         end
      end else begin
         cyc++;
      end
      if (mon_on && in_frame) begin
         if (cyc < total) begin
            check("line_level", tx, exp_bits[cyc / bitc]);
            check("busy_in_frame", busy, 1'b1);
         end else begin
            check("done_at_frame_end", tx_done, 1'b1);
            check("line_high_after_stop", tx, 1'b1);
            in_frame = 1'b0;
            frames_done++;
            gap_cnt = 1;
         end
      end
   end

   task automatic push_word(input logic [7:0] w, input bit scored);
      push_q.push_back(w);
      if (scored) sb.push_back(w);
   endtask

   task automatic set_cfg(input int div, input bit s2);
      baud_div   = 16'(div);
      cfg_div    = div;
      stop_bits2 = s2;
      cfg_stop2  = s2;
   endtask

   task automatic wait_re(input string tag, input int max);
      int n = 0;
      while (ifc.fifo_read_enable !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, ifc.fifo_read_enable, 1'b1);
   endtask

   task automatic wait_frames(input string tag, input int target, input int max);
      int n = 0;
      while (frames_done < target && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, frames_done >= target, 1'b1);
   endtask

   int n, hi, re0, dn0, fr0;

   initial begin
      resetn    = 1'b0;
      tx_enable = 1'b0;
      flush_req = 1'b0;
      mon_on    = 1'b1;
      set_cfg(0, 1'b0);
`ifdef UART_TX_PARITY_EN
      parity_en  = 1'b0;
      parity_odd = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_re", ifc.fifo_read_enable, 1'b0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      // 0xA5, 8N1, 4 clk per bit
      set_cfg(3, 1'b0);
      tx_enable = 1'b1;
      re0 = re_cnt; dn0 = done_cnt; fr0 = frames_done;
      push_word(8'hA5, 1'b1);
      wait_re("a5_re", 20);
      check("a5_busy_at_re", busy, 1'b1);
      @(negedge clk);
      check("a5_re_one_cycle", ifc.fifo_read_enable, 1'b0);
      check("a5_tx_idle_at_ack", tx, 1'b1);
      @(negedge clk);
      check("a5_start_latency", tx, 1'b0);
      n = 0;
      while (tx_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("a5_done_seen", tx_done, 1'b1);
      check("a5_busy_falls", busy, 1'b0);
      @(negedge clk);
      check("a5_done_pulse", tx_done, 1'b0);
      repeat (3) @(negedge clk);
      check("a5_re_count", re_cnt - re0, 1);
      check("a5_done_count", done_cnt - dn0, 1);
      check("a5_frames", frames_done - fr0, 1);

      // three back-to-back words at 1 clk per bit
      set_cfg(0, 1'b0);
      re0 = re_cnt; dn0 = done_cnt; fr0 = frames_done;
      gaps.delete();
      push_word(8'h00, 1'b1);
      push_word(8'hFF, 1'b1);
      push_word(8'h55, 1'b1);
      wait_frames("b2b_frames", fr0 + 3, 200);
      repeat (4) @(negedge clk);
      check("b2b_re_count", re_cnt - re0, 3);
      check("b2b_done_count", done_cnt - dn0, 3);
      check("b2b_gap_entries", gaps.size(), 3);
      check("b2b_gap_1", gaps[1], 2);
      check("b2b_gap_2", gaps[2], 2);
      check("b2b_fifo_empty", ifc.fifo_empty, 1'b1);
      check("b2b_busy_idle", busy, 1'b0);

      // 0x80 with two stop bits, 10 clk per bit; divisor changed mid-frame
      set_cfg(9, 1'b1);
      fr0 = frames_done;
      push_word(8'h80, 1'b1);
      wait_re("stop2_re", 20);
      hi = 0;
      n  = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (n == 5) baud_div = 16'd2;
         if (tx_done === 1'b1) break;
         if (tx === 1'b1) hi++;
         else hi = 0;
      end
      check("stop2_done_seen", tx_done, 1'b1);
      // bit 7 of 0x80 is high, so the run is 10 data cycles plus 20 stop cycles
      check("stop2_high_run", hi, 30);
      repeat (3) @(negedge clk);
      check("stop2_frames", frames_done - fr0, 1);

      // FIFO flushed between read request and ack
      set_cfg(1, 1'b0);
      re0 = re_cnt; dn0 = done_cnt;
      flush_req = 1'b1;
      push_word(8'h11, 1'b0);
      wait_re("flush_re", 20);
      @(negedge clk);
      check("flush_no_ack", ifc.fifo_read_ack, 1'b0);
      check("flush_busy_fetch", busy, 1'b1);
      check("flush_tx_fetch", tx, 1'b1);
      @(negedge clk);
      check("flush_busy_drop", busy, 1'b0);
      check("flush_tx_idle", tx, 1'b1);
      flush_req = 1'b0;
      repeat (10) @(negedge clk);
      check("flush_no_done", done_cnt - dn0, 0);
      check("flush_single_re", re_cnt - re0, 1);
      check("flush_tx_still_high", tx, 1'b1);

      // tx_enable gating: nothing starts while low; a frame in flight completes
      re0 = re_cnt; fr0 = frames_done;
      tx_enable = 1'b0;
      push_word(8'hC3, 1'b1);
      push_word(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      check("en_off_no_re", re_cnt - re0, 0);
      check("en_off_busy", busy, 1'b0);
      tx_enable = 1'b1;
      wait_re("en_on_re", 20);
      tx_enable = 1'b0;
      wait_frames("en_midframe_complete", fr0 + 1, 100);
      repeat (10) @(negedge clk);
      check("en_off_single_re", re_cnt - re0, 1);
      check("en_off_frames", frames_done - fr0, 1);
      check("en_off_word_kept", ifc.fifo_empty, 1'b0);
      tx_enable = 1'b1;
      wait_frames("en_resume_frame", fr0 + 2, 100);
      repeat (3) @(negedge clk);
      check("en_resume_re", re_cnt - re0, 2);

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: even parity bit 1, odd parity bit 0
      set_cfg(1, 1'b0);
      parity_en = 1'b1; cfg_par_en = 1'b1;
      parity_odd = 1'b0; cfg_par_odd = 1'b0;
      fr0 = frames_done;
      push_word(8'h07, 1'b1);
      wait_re("par_even_re", 20);
      repeat (20) @(negedge clk);
      check("par_even_0x07", tx, 1'b1);
      wait_frames("par_even_frame", fr0 + 1, 100);
      repeat (3) @(negedge clk);
      parity_odd = 1'b1; cfg_par_odd = 1'b1;
      push_word(8'h07, 1'b1);
      wait_re("par_odd_re", 20);
      repeat (20) @(negedge clk);
      check("par_odd_0x07", tx, 1'b0);
      wait_frames("par_odd_frame", fr0 + 2, 100);
      repeat (3) @(negedge clk);
      parity_en = 1'b0; cfg_par_en = 1'b0;
      parity_odd = 1'b0; cfg_par_odd = 1'b0;
`endif

      // asynchronous reset during data bit 3 of 0x3C
      mon_on = 1'b0;
      set_cfg(3, 1'b0);
      push_word(8'h3C, 1'b0);
      wait_re("rst_mid_re", 20);
      repeat (19) @(negedge clk);
      check("rst_mid_busy_before", busy, 1'b1);
      check("rst_mid_bit3", tx, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("rst_mid_tx", tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", tx_done, 1'b0);
      check("rst_mid_re_low", ifc.fifo_read_enable, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      re0 = re_cnt;
      repeat (12) @(negedge clk);
      check("rst_no_refetch", re_cnt - re0, 0);
      check("rst_after_busy", busy, 1'b0);
      check("rst_after_tx", tx, 1'b1);
      check("rst_fifo_empty", ifc.fifo_empty, 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
